fetch_pc_unit: RTL and testbench

- Owns the architectural program counter (R15) and fetches instructions from instruction memory through a req/ack handshake.
- Presents each fetched instruction to decode with a valid/ready handshake.
- Applies control-flow redirects: taken branches from execute, and writes to PC flagged by the register file.
- Sits directly upstream of the register file. It supplies the PC+8 value that is read as R15, and the link address written to R14 on BL.

---
 rtl/arm_core_pkg.sv | 21 ++
 rtl/pc_target_calc.sv | 20 ++
 rtl/fetch_pc_unit.sv | 146 ++++++++++++++
 tb/tb_fetch_pc_unit.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_core_pkg.sv
// Shared definitions for the ARM-style core front end: fetch state encoding,
// PC step constants and the branch target helper.
package arm_core_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StHold,
    StDrain
  } state_e;

  localparam logic [31:0] PC_INCR         = 32'd4;
  localparam logic [31:0] R15_READ_OFFSET = 32'd8;

  // Offset is a signed word count; the result wraps modulo 2^32.
  function automatic logic [31:0] branch_target(input logic [31:0] pc,
                                                input logic [23:0] offset24);
    return pc + R15_READ_OFFSET + {{6{offset24[23]}}, offset24, 2'b00};
  endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Combinational PC arithmetic: branch target, word-aligned R15 write target
// and the PC+8 value read back as R15.
module pc_target_calc
  import arm_core_pkg::*;
(
  input  logic [31:0] instr_pc_i,
  input  logic [23:0] branch_offset_i,
  input  logic [31:0] reg_pc_data_i,
  output logic [31:0] branch_target_o,
  output logic [31:0] reg_target_o,
  output logic [31:0] pc_plus8_o
);

  always_comb begin
    branch_target_o = branch_target(instr_pc_i, branch_offset_i);
    reg_target_o    = {reg_pc_data_i[31:2], 2'b00};
    pc_plus8_o      = instr_pc_i + R15_READ_OFFSET;
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter owner and instruction fetcher: req/ack fetch from imem,
// valid/ready hand-off to decode, branch and R15-write redirects.
module fetch_pc_unit
  import arm_core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch_taken,
  input  logic [23:0] branch_offset,
  input  logic        branch_link,
  input  logic        reg_pc_write,
  input  logic [31:0] reg_pc_data,
  output logic [31:0] pc_plus8,
  output logic [31:0] link_addr,
  output logic        link_valid
);

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] link_addr_q, link_addr_d;
  logic        link_valid_q, link_valid_d;

  logic [31:0] br_target;
  logic [31:0] reg_target;

  pc_target_calc u_pc_target_calc (
    .instr_pc_i      (instr_pc_q),
    .branch_offset_i (branch_offset),
    .reg_pc_data_i   (reg_pc_data),
    .branch_target_o (br_target),
    .reg_target_o    (reg_target),
    .pc_plus8_o      (pc_plus8)
  );

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    redirect_pc_d = redirect_pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    link_addr_d   = link_addr_q;
    link_valid_d  = 1'b0;

    unique case (state_q)
      StIdle: state_d = StFetch;

      StFetch: begin
        if (reg_pc_write) begin
          // An ack in the same cycle is simply dropped; refetch from the target.
          if (imem_ack) begin
            fetch_pc_d = reg_target;
          end else begin
            redirect_pc_d = reg_target;
            state_d       = StDrain;
          end
        end else if (imem_ack) begin
          instr_d       = imem_rdata;
          instr_pc_d    = fetch_pc_q;
          instr_valid_d = 1'b1;
          fetch_pc_d    = fetch_pc_q + PC_INCR;
          state_d       = StHold;
        end
      end

      StHold: begin
        if (reg_pc_write) begin
          // R15 write beats a simultaneous branch and kills any link pulse.
          instr_valid_d = 1'b0;
          fetch_pc_d    = reg_target;
          state_d       = StFetch;
        end else if (instr_ready) begin
          instr_valid_d = 1'b0;
          state_d       = StFetch;
          if (branch_taken) begin
            fetch_pc_d = br_target;
            if (branch_link) begin
              link_valid_d = 1'b1;
              link_addr_d  = instr_pc_q + PC_INCR;
            end
          end
        end
      end

      StDrain: begin
        if (reg_pc_write) begin
          redirect_pc_d = reg_target;
        end
        if (imem_ack) begin
          fetch_pc_d = reg_pc_write ? reg_target : redirect_pc_q;
          state_d    = StFetch;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      fetch_pc_q    <= RESET_PC;
      redirect_pc_q <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      link_addr_q   <= '0;
      link_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      redirect_pc_q <= redirect_pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      link_addr_q   <= link_addr_d;
      link_valid_q  <= link_valid_d;
    end
  end

  always_comb begin
    imem_req  = (state_q == StFetch) || (state_q == StDrain);
    imem_addr = imem_req ? fetch_pc_q : '0;
  end

  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign link_addr   = link_addr_q;
  assign link_valid  = link_valid_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed corner cases, then random traffic checked
// by a scoreboard fed from a PC-sequence reference model.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch_taken;
  logic [23:0] branch_offset;
  logic        branch_link;
  logic        reg_pc_write;
  logic [31:0] reg_pc_data;
  logic [31:0] pc_plus8;
  logic [31:0] link_addr;
  logic        link_valid;

  fetch_pc_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .branch_link   (branch_link),
    .reg_pc_write  (reg_pc_write),
    .reg_pc_data   (reg_pc_data),
    .pc_plus8      (pc_plus8),
    .link_addr     (link_addr),
    .link_valid    (link_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  int          total = 0;
  int          bad = 0;
  int          wait_left = -1;
  int          n_pres = 0;
  bit          sb_en = 1'b0;
  bit          presented = 1'b0;
  exp_t        exp_q[$];
  logic [31:0] link_q[$];
  exp_t        sb_e;
  logic [31:0] held_pc, held_instr;
  logic [31:0] model_pc;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory responder: answers each new request after dly wait cycles.
  task automatic mem_tick(input int dly);
    if (imem_req) begin
      if (wait_left < 0) wait_left = dly;
      if (wait_left == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = mem(imem_addr);
        wait_left  = -1;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        wait_left--;
      end
    end else begin
      imem_ack  = 1'b0;
      wait_left = -1;
    end
  endtask

  task automatic push_next(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.word = mem(pc);
    exp_q.push_back(e);
    model_pc = pc;
  endtask

  // Scoreboard monitor: compares each newly presented instruction and link pulse.
  always @(negedge clk) begin
    if (sb_en) begin
      if (instr_valid) begin
        if (!presented) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_underflow: got instr_pc %h, want no instruction", instr_pc);
          end else begin
            sb_e = exp_q.pop_front();
            chk("sb_pc", instr_pc, sb_e.pc);
            chk("sb_instr", instr, sb_e.word);
            chk("sb_pc_plus8", pc_plus8, sb_e.pc + 32'd8);
            held_pc    = instr_pc;
            held_instr = instr;
            n_pres++;
          end
          presented = 1'b1;
        end else begin
          chk("sb_hold_pc", instr_pc, held_pc);
          chk("sb_hold_instr", instr, held_instr);
        end
      end else begin
        presented = 1'b0;
      end
      if (link_valid) begin
        if (link_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_link_unexpected: got link_addr %h, want no pulse", link_addr);
        end else begin
          chk("sb_link_addr", link_addr, link_q.pop_front());
        end
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"}, 32'(imem_req), 32'd0);
    chk({tag, "_addr"}, imem_addr, 32'd0);
    chk({tag, "_instr"}, instr, 32'd0);
    chk({tag, "_instr_pc"}, instr_pc, 32'd0);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_link_addr"}, link_addr, 32'd0);
    chk({tag, "_link_valid"}, 32'(link_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] nxt;
    int          o;

    reset = 1'b1; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
    branch_taken = 1'b0; branch_offset = '0; branch_link = 1'b0;
    reg_pc_write = 1'b0; reg_pc_data = '0;
    step(); step();
    chk_reset_outputs("rst");

    // Straight-line fetch, then decode stall at pc 8.
    reset = 1'b0; instr_ready = 1'b1;
    step(); chk("t1_req", 32'(imem_req), 32'd1); chk("t1_addr", imem_addr, 32'd0);
    chk("t1_valid", 32'(instr_valid), 32'd0); mem_tick(0);
    step(); chk("t2_valid", 32'(instr_valid), 32'd1); chk("t2_pc", instr_pc, 32'd0);
    chk("t2_instr", instr, mem(32'd0)); mem_tick(0);
    step(); chk("t3_addr", imem_addr, 32'd4); mem_tick(0);
    step(); chk("t4_pc", instr_pc, 32'd4); mem_tick(0);
    step(); chk("t5_addr", imem_addr, 32'd8); mem_tick(0); instr_ready = 1'b0;
    step(); chk("t6_pc", instr_pc, 32'd8);
    repeat (5) begin
      step(); mem_tick(0);
      chk("stall_valid", 32'(instr_valid), 32'd1); chk("stall_pc", instr_pc, 32'd8);
      chk("stall_instr", instr, mem(32'd8)); chk("stall_req", 32'(imem_req), 32'd0);
    end
    instr_ready = 1'b1;
    step(); chk("resume_req", 32'(imem_req), 32'd1); chk("resume_addr", imem_addr, 32'd12);
    mem_tick(0); instr_ready = 1'b0;
    step(); mem_tick(0);

    // R15 write in HOLD drops the held instruction.
    reg_pc_write = 1'b1; reg_pc_data = 32'h100;
    step(); reg_pc_write = 1'b0;
    chk("drop_valid", 32'(instr_valid), 32'd0); chk("drop_addr", imem_addr, 32'h100);
    mem_tick(0);
    step(); chk("b_pc", instr_pc, 32'h100); mem_tick(0);

    // BL with offset -2 words.
    branch_taken = 1'b1; branch_offset = 24'hFFFFFE; branch_link = 1'b1; instr_ready = 1'b1;
    step(); branch_taken = 1'b0; branch_link = 1'b0; instr_ready = 1'b0;
    chk("bl_addr", imem_addr, 32'h100); chk("bl_link_valid", 32'(link_valid), 32'd1);
    chk("bl_link_addr", link_addr, 32'h104);

    // R15 write while the fetch is outstanding: drain, then redirect.
    reg_pc_write = 1'b1; reg_pc_data = 32'h2003;
    step(); reg_pc_write = 1'b0;
    chk("drain_req", 32'(imem_req), 32'd1); chk("drain_addr", imem_addr, 32'h100);
    step(); chk("bl_pulse_end", 32'(link_valid), 32'd0); chk("drain_addr2", imem_addr, 32'h100);
    step(); chk("drain_valid", 32'(instr_valid), 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step(); imem_ack = 1'b0;
    chk("redir_addr", imem_addr, 32'h2000); chk("redir_valid", 32'(instr_valid), 32'd0);
    mem_tick(0);
    step(); chk("redir_pc", instr_pc, 32'h2000); chk("redir_instr", instr, mem(32'h2000));
    mem_tick(0);

    // R15 write and accepted BL together: write wins, no link pulse.
    branch_taken = 1'b1; branch_link = 1'b1; branch_offset = 24'd5; instr_ready = 1'b1;
    reg_pc_write = 1'b1; reg_pc_data = 32'h400;
    step(); branch_taken = 1'b0; branch_link = 1'b0; instr_ready = 1'b0; reg_pc_write = 1'b0;
    chk("both_addr", imem_addr, 32'h400); chk("both_link", 32'(link_valid), 32'd0);
    step(); chk("both_link2", 32'(link_valid), 32'd0); mem_tick(0);
    step(); chk("both_pc", instr_pc, 32'h400); mem_tick(0);

    // Wrap-around at the top of the address space.
    reg_pc_write = 1'b1; reg_pc_data = 32'hFFFF_FFFF;
    step(); reg_pc_write = 1'b0; chk("wrap_addr", imem_addr, 32'hFFFF_FFFC); mem_tick(0);
    step(); chk("wrap_pc", instr_pc, 32'hFFFF_FFFC); mem_tick(0); instr_ready = 1'b1;
    step(); instr_ready = 1'b0;
    chk("wrap_next_req", 32'(imem_req), 32'd1); chk("wrap_next_addr", imem_addr, 32'd0);

    // Ack and R15 write in the same FETCH cycle.
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0; reg_pc_write = 1'b1; reg_pc_data = 32'h808;
    step(); imem_ack = 1'b0; reg_pc_write = 1'b0;
    chk("ackw_addr", imem_addr, 32'h808); chk("ackw_valid", 32'(instr_valid), 32'd0);

    // Reset during DRAIN, with a late ack that must be ignored.
    reg_pc_write = 1'b1; reg_pc_data = 32'h3000;
    step(); reg_pc_write = 1'b0; chk("dr_addr", imem_addr, 32'h808);
    reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    step(); chk_reset_outputs("mid_rst");
    reset = 1'b0;
    step(); chk("post_req", 32'(imem_req), 32'd1); chk("post_addr", imem_addr, 32'd0);
    chk("post_valid", 32'(instr_valid), 32'd0);
    imem_ack = 1'b0;

    // Random traffic against the PC-sequence model.
    reset = 1'b1; wait_left = -1;
    step(); step();
    reset = 1'b0;
    exp_q.delete(); link_q.delete(); presented = 1'b0;
    push_next(32'd0);
    sb_en = 1'b1;
    repeat (4000) begin
      step();
      mem_tick($urandom_range(0, 3));
      instr_ready   = ($urandom_range(0, 9) < 7);
      branch_taken  = ($urandom_range(0, 3) == 0);
      branch_link   = 1'($urandom_range(0, 1));
      branch_offset = 24'($urandom_range(0, 255)) - 24'd128;
      if ($urandom_range(0, 7) == 0) branch_offset = 24'($urandom);
      reg_pc_data   = $urandom;
      reg_pc_write  = 1'b0;
      if (instr_valid) begin
        reg_pc_write = ($urandom_range(0, 9) == 0);
        if (reg_pc_write) begin
          push_next(reg_pc_data & 32'hFFFF_FFFC);
        end else if (instr_ready) begin
          if (branch_taken) begin
            o = int'(branch_offset);
            if (o >= (1 << 23)) o = o - (1 << 24);
            nxt = model_pc + 32'(8 + 4 * o);
            if (branch_link) link_q.push_back(model_pc + 32'd4);
            push_next(nxt);
          end else begin
            push_next(model_pc + 32'd4);
          end
        end
      end
    end
    step(); step();
    sb_en = 1'b0;
    chk("sb_link_leftover", 32'(link_q.size()), 32'd0);
    chk("sb_enough_traffic", 32'(n_pres >= 200), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
